// File: rtl/accel_seq.sv
// accel_seq
// Command sequencer between the bus-side registers and the off-chip
// memristor array. One array operation is accepted at a time through a
// valid/ready command port. The sequencer then walks SETUP -> PULSE -> HOLD,
// driving registered chip strobes, the op code and the row/column address.
// It captures the array output at the end of the pulse and returns it through
// a valid/ready response port.
//
// Ports
//   clk_sys_in, rst_sys_in            clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op/cmd_col/cmd_row/cmd_wdata  command payload (latched on accept)
//   rsp_valid/rsp_ready/rsp_data      response handshake and captured data
//   busy                              high whenever not IDLE
//   CBL/CBLEN/CSL/CWL                 chip strobes (registered)
//   instructions/addr_col/addr_row    chip op code and address (registered)
//   bit_in                            chip data out, bit i = array i
module accel_seq #(
    parameter int AddrW    = 5,
    parameter int NArray   = 4,
    parameter int SetupCyc = 2,
    parameter int PulseCyc = 4,
    parameter int HoldCyc  = 2
) (
    input  logic              clk_sys_in,
    input  logic              rst_sys_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AddrW-1:0]  cmd_col,
    input  logic [AddrW-1:0]  cmd_row,
    input  logic              cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NArray-1:0] rsp_data,
    output logic              busy,
    output logic              CBL,
    output logic              CBLEN,
    output logic              CSL,
    output logic              CWL,
    output logic [1:0]        instructions,
    output logic [AddrW-1:0]  addr_col,
    output logic [AddrW-1:0]  addr_row,
    input  logic [NArray-1:0] bit_in
);

    // A phase length of zero would make the phase vanish; clamp to one cycle.
    localparam int SetupEff = (SetupCyc < 1) ? 1 : SetupCyc;
    localparam int PulseEff = (PulseCyc < 1) ? 1 : PulseCyc;
    localparam int HoldEff  = (HoldCyc  < 1) ? 1 : HoldCyc;
    localparam int MaxSP    = (SetupEff > PulseEff) ? SetupEff : PulseEff;
    localparam int MaxCyc   = (MaxSP > HoldEff) ? MaxSP : HoldEff;
    localparam int CntW     = $clog2(MaxCyc) + 1;

    localparam logic [1:0] OP_PROG     = 2'b11;
    localparam logic [1:0] OP_READ_MEM = 2'b10;
    localparam logic [1:0] OP_READ_REG = 2'b01;
    localparam logic [1:0] OP_INFER    = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CntW-1:0]    cnt_reg, cnt_next;
    logic [1:0]         op_reg, op_next;
    logic [AddrW-1:0]   col_reg, col_next;
    logic [AddrW-1:0]   row_reg, row_next;
    logic               wdata_reg, wdata_next;
    logic [NArray-1:0]  rsp_data_reg, rsp_data_next;
    logic               cbl_reg, cbl_next;
    logic               cblen_reg, cblen_next;
    logic               csl_reg, csl_next;
    logic               cwl_reg, cwl_next;
    logic [1:0]         instr_reg, instr_next;
    logic [AddrW-1:0]   addr_col_reg, addr_col_next;
    logic [AddrW-1:0]   addr_row_reg, addr_row_next;
    logic [NArray-1:0]  capture_bits;

    // A prog returns zero, so every captured bit is masked by the op.
    for (genvar gi = 0; gi < NArray; gi++) begin : g_capture
        assign capture_bits[gi] = bit_in[gi] & (op_reg != OP_PROG);
    end

    always_ff @(posedge clk_sys_in) begin
        if (rst_sys_in) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            wdata_reg    <= 1'b0;
            rsp_data_reg <= '0;
            cbl_reg      <= 1'b0;
            cblen_reg    <= 1'b0;
            csl_reg      <= 1'b0;
            cwl_reg      <= 1'b0;
            instr_reg    <= '0;
            addr_col_reg <= '0;
            addr_row_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            wdata_reg    <= wdata_next;
            rsp_data_reg <= rsp_data_next;
            cbl_reg      <= cbl_next;
            cblen_reg    <= cblen_next;
            csl_reg      <= csl_next;
            cwl_reg      <= cwl_next;
            instr_reg    <= instr_next;
            addr_col_reg <= addr_col_next;
            addr_row_reg <= addr_row_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        wdata_next    = wdata_reg;
        rsp_data_next = rsp_data_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next    = cmd_op;
                    col_next   = cmd_col;
                    row_next   = cmd_row;
                    wdata_next = cmd_wdata;
                    state_next = SETUP;
                    cnt_next   = CntW'(SetupEff - 1);
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = PULSE;
                    cnt_next   = CntW'(PulseEff - 1);
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    rsp_data_next = capture_bits;
                    state_next    = HOLD;
                    cnt_next      = CntW'(HoldEff - 1);
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Chip outputs are decoded from the next state so the registered strobes
    // line up cycle-for-cycle with the state register. Address and op code are
    // only non-zero across SETUP/PULSE/HOLD, so they never move under a strobe.
    always_comb begin
        cbl_next      = 1'b0;
        cblen_next    = 1'b0;
        csl_next      = 1'b0;
        cwl_next      = 1'b0;
        instr_next    = '0;
        addr_col_next = '0;
        addr_row_next = '0;
        if (state_next == SETUP || state_next == PULSE || state_next == HOLD) begin
            instr_next    = op_next;
            addr_col_next = col_next;
            addr_row_next = row_next;
        end
        if (state_next == PULSE) begin
            case (op_next)
                OP_PROG: begin
                    csl_next   = 1'b1;
                    cwl_next   = 1'b1;
                    cblen_next = 1'b1;
                    cbl_next   = wdata_next;
                end
                OP_READ_MEM: begin
                    csl_next   = 1'b1;
                    cblen_next = 1'b1;
                end
                OP_INFER: begin
                    csl_next = 1'b1;
                end
                OP_READ_REG: begin
                    csl_next = 1'b0;
                end
                default: csl_next = 1'b0;
            endcase
        end
    end

    assign cmd_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign rsp_valid    = (state_reg == DONE);
    assign rsp_data     = rsp_data_reg;
    assign CBL          = cbl_reg;
    assign CBLEN        = cblen_reg;
    assign CSL          = csl_reg;
    assign CWL          = cwl_reg;
    assign instructions = instr_reg;
    assign addr_col     = addr_col_reg;
    assign addr_row     = addr_row_reg;

endmodule

// File: tb/tb_accel_seq.sv
// tb_accel_seq
// Drives two accel_seq instances (default timing and a 0/1/0 timing) with
// directed and $urandom commands. A per-cycle timeline model derived from the
// phase lengths predicts every chip output, handshake signal and response.
module tb_accel_seq;
    localparam int AW = 5;
    localparam int NA = 4;
    localparam int A_S = 2, A_P = 4, A_H = 2;
    localparam int B_S = 0, B_P = 1, B_H = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_col, cmd_row;
    logic          cmd_wdata;
    logic [NA-1:0] bit_in;
    logic          cmd_valid_a, rsp_ready_a, cmd_valid_b, rsp_ready_b;

    logic          cmd_ready_a, rsp_valid_a, busy_a, cbl_a, cblen_a, csl_a, cwl_a;
    logic [NA-1:0] rsp_data_a;
    logic [1:0]    instr_a;
    logic [AW-1:0] col_a, row_a;
    logic          cmd_ready_b, rsp_valid_b, busy_b, cbl_b, cblen_b, csl_b, cwl_b;
    logic [NA-1:0] rsp_data_b;
    logic [1:0]    instr_b;
    logic [AW-1:0] col_b, row_b;

    accel_seq #(.AddrW(AW), .NArray(NA), .SetupCyc(A_S), .PulseCyc(A_P), .HoldCyc(A_H)) dut_a (
        .clk_sys_in(clk), .rst_sys_in(rst),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op),
        .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
        .busy(busy_a), .CBL(cbl_a), .CBLEN(cblen_a), .CSL(csl_a), .CWL(cwl_a),
        .instructions(instr_a), .addr_col(col_a), .addr_row(row_a), .bit_in(bit_in)
    );

    accel_seq #(.AddrW(AW), .NArray(NA), .SetupCyc(B_S), .PulseCyc(B_P), .HoldCyc(B_H)) dut_b (
        .clk_sys_in(clk), .rst_sys_in(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
        .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .busy(busy_b), .CBL(cbl_b), .CBLEN(cblen_b), .CSL(csl_b), .CWL(cwl_b),
        .instructions(instr_b), .addr_col(col_b), .addr_row(row_b), .bit_in(bit_in)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int c);
        return (c < 1) ? 1 : c;
    endfunction

    // Bundle layout: {CBL,CBLEN,CSL,CWL, instr, col, row, cmd_ready, busy, rsp_valid}
    function automatic logic [18:0] obs_bundle(input bit sel);
        if (sel)
            return {cbl_b, cblen_b, csl_b, cwl_b, instr_b, col_b, row_b, cmd_ready_b, busy_b, rsp_valid_b};
        return {cbl_a, cblen_a, csl_a, cwl_a, instr_a, col_a, row_a, cmd_ready_a, busy_a, rsp_valid_a};
    endfunction

    // Strobe pattern while the pulse is active, {CBL,CBLEN,CSL,CWL}.
    function automatic logic [3:0] pulse_strobes(input logic [1:0] op, input logic wdata);
        case (op)
            2'b11:   return {wdata, 1'b1, 1'b1, 1'b1};
            2'b10:   return 4'b0110;
            2'b00:   return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    // phase: 0 idle, 1 setup, 2 pulse, 3 hold, 4 done
    function automatic logic [18:0] exp_bundle(input int phase, input logic [1:0] op,
                                               input logic [AW-1:0] col, input logic [AW-1:0] row,
                                               input logic wdata);
        logic [3:0]    st;
        logic [1:0]    ins;
        logic [AW-1:0] c, r;
        st  = (phase == 2) ? pulse_strobes(op, wdata) : 4'b0000;
        ins = (phase >= 1 && phase <= 3) ? op  : 2'b00;
        c   = (phase >= 1 && phase <= 3) ? col : '0;
        r   = (phase >= 1 && phase <= 3) ? row : '0;
        return {st, ins, c, r, phase == 0, phase != 0, phase == 4};
    endfunction

    task automatic set_valid(input bit sel, input logic v);
        if (sel) cmd_valid_b = v; else cmd_valid_a = v;
    endtask

    task automatic set_ready(input bit sel, input logic v);
        if (sel) rsp_ready_b = v; else rsp_ready_a = v;
    endtask

    task automatic scramble_cmd();
        cmd_op    = 2'($urandom);
        cmd_col   = AW'($urandom);
        cmd_row   = AW'($urandom);
        cmd_wdata = 1'($urandom);
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // after the response handshake, having checked that the DUT is idle again.
    task automatic run_op(input bit sel, input int s, input int p, input int h,
                          input logic [1:0] op, input logic [AW-1:0] col, input logic [AW-1:0] row,
                          input logic wdata, input int bp, input bit hold_valid,
                          input bit use_fixed, input logic [NA-1:0] fixed_bits);
        int            len;
        int            phase;
        logic [NA-1:0] exp_rsp;
        len       = s + p + h;
        exp_rsp   = '0;
        cmd_op    = op;
        cmd_col   = col;
        cmd_row   = row;
        cmd_wdata = wdata;
        set_valid(sel, 1'b1);
        set_ready(sel, 1'b0);
        check_eq($sformatf("pre_accept op%0b", op), 32'(obs_bundle(sel)), 32'(exp_bundle(0, op, col, row, wdata)));
        @(posedge clk);
        @(negedge clk);
        set_valid(sel, hold_valid);
        scramble_cmd();
        for (int j = 0; j < len; j++) begin
            phase = (j < s) ? 1 : (j < s + p) ? 2 : 3;
            check_eq($sformatf("op%0b c%0d r%0d cyc%0d", op, col, row, j), 32'(obs_bundle(sel)),
                     32'(exp_bundle(phase, op, col, row, wdata)));
            bit_in = use_fixed ? fixed_bits : NA'($urandom);
            if (j == s + p - 1) exp_rsp = (op == 2'b11) ? '0 : bit_in;
            if (hold_valid) scramble_cmd();
            @(negedge clk);
        end
        for (int d = 0; d <= bp; d++) begin
            check_eq($sformatf("done op%0b wait%0d", op, d), 32'(obs_bundle(sel)), 32'(exp_bundle(4, op, col, row, wdata)));
            check_eq($sformatf("rsp_data op%0b wait%0d", op, d), 32'(sel ? rsp_data_b : rsp_data_a), 32'(exp_rsp));
            bit_in = NA'($urandom);
            if (hold_valid) scramble_cmd();
            if (d == bp) set_ready(sel, 1'b1);
            @(negedge clk);
        end
        set_ready(sel, 1'b0);
        check_eq($sformatf("back_idle op%0b", op), 32'(obs_bundle(sel)), 32'(exp_bundle(0, op, col, row, wdata)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_rand;
        rst = 1'b1;
        cmd_valid_a = 1'b0; rsp_ready_a = 1'b0;
        cmd_valid_b = 1'b0; rsp_ready_b = 1'b0;
        cmd_op = '0; cmd_col = '0; cmd_row = '0; cmd_wdata = 1'b0; bit_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_a", 32'(obs_bundle(1'b0)), 32'(exp_bundle(0, 2'b00, '0, '0, 1'b0)));
        check_eq("reset_b", 32'(obs_bundle(1'b1)), 32'(exp_bundle(0, 2'b00, '0, '0, 1'b0)));
        check_eq("reset_rsp_data", 32'(rsp_data_a), 32'(0));
        @(negedge clk);

        // read_mem col 5 row 17 with a known array output
        run_op(1'b0, A_S, A_P, A_H, 2'b10, 5'd5, 5'd17, 1'b0, 0, 1'b0, 1'b1, 4'b1010);
        // prog col 31 row 0 with wdata 1
        run_op(1'b0, A_S, A_P, A_H, 2'b11, 5'd31, 5'd0, 1'b1, 0, 1'b0, 1'b0, 4'b0000);
        // back-pressure: response held for 10 extra cycles
        run_op(1'b0, A_S, A_P, A_H, 2'b00, 5'd9, 5'd22, 1'b0, 10, 1'b0, 1'b1, 4'b0110);
        // back-to-back with cmd_valid held: read_reg then inference
        run_op(1'b0, A_S, A_P, A_H, 2'b01, 5'd3, 5'd4, 1'b1, 0, 1'b1, 1'b1, 4'b1111);
        run_op(1'b0, A_S, A_P, A_H, 2'b00, 5'd12, 5'd30, 1'b0, 0, 1'b0, 1'b1, 4'b0101);

        // reset in the middle of a prog pulse drops the command
        cmd_op = 2'b11; cmd_col = 5'd7; cmd_row = 5'd8; cmd_wdata = 1'b1;
        cmd_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_a = 1'b0;
        repeat (A_S + 1) @(negedge clk);
        check_eq("mid_pulse", 32'(obs_bundle(1'b0)), 32'(exp_bundle(2, 2'b11, 5'd7, 5'd8, 1'b1)));
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("in_reset%0d", k), 32'(obs_bundle(1'b0)), 32'(exp_bundle(0, 2'b00, '0, '0, 1'b0)));
            check_eq($sformatf("in_reset_rsp%0d", k), 32'(rsp_data_a), 32'(0));
        end
        rst = 1'b0;
        for (int k = 0; k < A_S + A_P + A_H + 2; k++) begin
            @(negedge clk);
            check_eq($sformatf("post_reset%0d", k), 32'(obs_bundle(1'b0)), 32'(exp_bundle(0, 2'b00, '0, '0, 1'b0)));
        end

        // randomized traffic on the default-timing instance
        n_rand = 30;
        for (int i = 0; i < n_rand; i++) begin
            run_op(1'b0, A_S, A_P, A_H, 2'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), (i != n_rand - 1) && ($urandom_range(0, 1) == 1), 1'b0, '0);
        end
        cmd_valid_a = 1'b0;
        @(negedge clk);

        // zero-length phases clamp to one cycle each
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, eff(B_S), eff(B_P), eff(B_H), 2'($urandom), AW'($urandom), AW'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
